// File: rtl/prog_count_n_if.sv
// Control/status bundle for prog_count_n.
// The master drives the run controls and observes the count; the slave is the counter.
interface prog_count_n_if #(
   parameter int unsigned WIDTH = 7
);
   logic             run;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] max_count;
   logic [WIDTH-1:0] count_out;
   logic             done;
   logic             tc;
   logic [7:0]       wraps;

   modport master (
      output run, en, mode, max_count,
      input  count_out, done, tc, wraps
   );

   modport slave (
      input  run, en, mode, max_count,
      output count_out, done, tc, wraps
   );
endinterface

// File: rtl/prog_count_n.sv
// Programmable up-counter with one-shot/wrap modes, a clamped terminal value latched per run,
// and a saturating wrap counter. Every output comes straight from a flop.
module prog_count_n #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned LIMIT = 99
) (
   input logic            CLK,
   input logic            reset,
   prog_count_n_if.slave  bus
);

   localparam logic [WIDTH-1:0] LimitW   = WIDTH'(LIMIT);
   localparam logic [7:0]       WrapsMax = 8'hFF;

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] emax_q;
   logic             mode_q;
   logic             done_q;
   logic             tc_q;
   logic [7:0]       wraps_q;
   logic [WIDTH-1:0] emax;

   assign emax = (bus.max_count > LimitW) ? LimitW : bus.max_count;

   // Terminal is tested with >= so a corrupted count can never run past emax_q.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         emax_q  <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         tc_q    <= 1'b0;
         wraps_q <= '0;
      end else begin
         tc_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.run) begin
                  state_q <= StCount;
                  emax_q  <= emax;
                  mode_q  <= bus.mode;
                  count_q <= '0;
                  wraps_q <= '0;
                  done_q  <= 1'b0;
               end
            end
            StCount: begin
               if (!bus.run) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
               end else if (bus.en) begin
                  if (count_q >= emax_q) begin
                     tc_q <= 1'b1;
                     if (mode_q) begin
                        count_q <= '0;
                        if (wraps_q != WrapsMax) begin
                           wraps_q <= wraps_q + 8'd1;
                        end
                     end else begin
                        state_q <= StDone;
                        count_q <= emax_q;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            StDone: begin
               if (!bus.run) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count_out = count_q;
   assign bus.done      = done_q;
   assign bus.tc        = tc_q;
   assign bus.wraps     = wraps_q;

endmodule

// File: tb/tb_prog_count_n.sv
// Directed bench for prog_count_n: a behavioural run model checked on every falling edge,
// plus hand-computed literal checks per scenario.
module tb_prog_count_n;

   localparam int unsigned WIDTH = 7;
   localparam int unsigned LIMIT = 99;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   prog_count_n_if #(.WIDTH(WIDTH)) bus ();

   prog_count_n #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Model: a run is "active" while counting and "finished" after a one-shot terminal.
   bit m_active = 0, m_fin = 0, m_mode = 0, m_tc = 0;
   int m_emax = 0, m_cnt = 0, m_wraps = 0;

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         m_active = 0; m_fin = 0; m_mode = 0; m_tc = 0;
         m_emax = 0; m_cnt = 0; m_wraps = 0;
      end else begin
         m_tc = 0;
         if (!m_active && !m_fin) begin
            if (bus.run) begin
               m_active = 1;
               m_emax   = (int'(bus.max_count) > LIMIT) ? LIMIT : int'(bus.max_count);
               m_mode   = bus.mode;
               m_cnt    = 0;
               m_wraps  = 0;
            end
         end else if (!bus.run) begin
            m_active = 0;
            m_fin    = 0;
         end else if (m_active && bus.en) begin
            if (m_cnt == m_emax) begin
               m_tc = 1;
               if (m_mode) begin
                  m_cnt   = 0;
                  m_wraps = (m_wraps == 255) ? 255 : m_wraps + 1;
               end else begin
                  m_active = 0;
                  m_fin    = 1;
               end
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      chk("model_count", 32'(bus.count_out), 32'(m_cnt));
      chk("model_done",  32'(bus.done),      32'(m_fin));
      chk("model_tc",    32'(bus.tc),        32'(m_tc));
      chk("model_wraps", 32'(bus.wraps),     32'(m_wraps));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int maxseen;
   int guard;

   initial begin
      bus.run = 0; bus.en = 0; bus.mode = 0; bus.max_count = '0;
      #12 reset = 0;
      tick(1);
      chk("reset_count", 32'(bus.count_out), 0);
      chk("reset_done",  32'(bus.done), 0);
      chk("reset_wraps", 32'(bus.wraps), 0);

      // One-shot to 5
      bus.max_count = 7'd5; bus.mode = 0; bus.en = 1; bus.run = 1;
      tick(1);
      for (int i = 0; i <= 5; i++) begin
         chk("os_seq", 32'(bus.count_out), 32'(i));
         chk("os_tc_low", 32'(bus.tc), 0);
         tick(1);
      end
      chk("os_done", 32'(bus.done), 1);
      chk("os_tc", 32'(bus.tc), 1);
      chk("os_hold", 32'(bus.count_out), 5);
      tick(1);
      chk("os_tc_once", 32'(bus.tc), 0);
      chk("os_hold2", 32'(bus.count_out), 5);
      bus.run = 0;
      tick(1);
      chk("os_idle_done", 32'(bus.done), 0);
      chk("os_idle_hold", 32'(bus.count_out), 5);

      // Clamp 120 -> 99
      bus.max_count = 7'd120; bus.run = 1;
      tick(1);
      maxseen = 0; guard = 0;
      while (!bus.done && guard < 150) begin
         if (int'(bus.count_out) > maxseen) maxseen = int'(bus.count_out);
         tick(1);
         guard++;
      end
      chk("clamp_max", 32'(maxseen), 99);
      chk("clamp_count", 32'(bus.count_out), 99);
      chk("clamp_done", 32'(bus.done), 1);
      bus.run = 0;
      tick(1);

      // Wrap at 3
      bus.max_count = 7'd3; bus.mode = 1; bus.run = 1;
      tick(1);
      bus.mode = 0;
      for (int i = 0; i < 12; i++) begin
         chk("wrap_seq", 32'(bus.count_out), 32'(i % 4));
         chk("wrap_tc", 32'(bus.tc), (i % 4 == 0 && i > 0) ? 1 : 0);
         if (i < 11) tick(1);
      end
      chk("wrap_wraps", 32'(bus.wraps), 2);
      chk("wrap_done", 32'(bus.done), 0);
      bus.run = 0;
      tick(1);

      // Pause at 2, max_count changed mid-run
      bus.max_count = 7'd5; bus.run = 1;
      tick(3);
      chk("pause_at", 32'(bus.count_out), 2);
      bus.en = 0; bus.max_count = 7'd1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("pause_hold", 32'(bus.count_out), 2);
      end
      bus.en = 1;
      tick(3);
      chk("pause_resume", 32'(bus.count_out), 5);
      chk("pause_not_done", 32'(bus.done), 0);
      tick(1);
      chk("pause_done", 32'(bus.done), 1);
      chk("pause_final", 32'(bus.count_out), 5);
      bus.run = 0;
      tick(1);

      // Abort on the terminal edge
      bus.max_count = 7'd2; bus.run = 1;
      tick(3);
      chk("abort_at", 32'(bus.count_out), 2);
      bus.run = 0;
      tick(1);
      chk("abort_tc", 32'(bus.tc), 0);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_hold", 32'(bus.count_out), 2);
      bus.run = 1;
      tick(1);
      chk("abort_restart", 32'(bus.count_out), 0);
      bus.run = 0;
      tick(1);

      // emax = 0, one-shot then wrap
      bus.max_count = 7'd0; bus.mode = 0; bus.run = 1;
      tick(2);
      chk("zero_os_done", 32'(bus.done), 1);
      chk("zero_os_tc", 32'(bus.tc), 1);
      bus.run = 0;
      tick(1);
      bus.mode = 1; bus.run = 1;
      tick(2);
      chk("zero_wr_tc1", 32'(bus.tc), 1);
      tick(1);
      chk("zero_wr_tc2", 32'(bus.tc), 1);
      chk("zero_wr_wraps", 32'(bus.wraps), 2);
      tick(300);
      chk("wraps_sat", 32'(bus.wraps), 255);
      bus.run = 0;
      tick(1);
      chk("wraps_hold", 32'(bus.wraps), 255);

      // Async reset between edges at count 4
      bus.max_count = 7'd10; bus.mode = 0; bus.run = 1;
      tick(5);
      chk("rst_pre", 32'(bus.count_out), 4);
      #1 reset = 1;
      #1;
      chk("rst_count", 32'(bus.count_out), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_tc", 32'(bus.tc), 0);
      chk("rst_wraps", 32'(bus.wraps), 0);
      reset = 0;
      bus.run = 0;
      tick(3);
      chk("rst_idle", 32'(bus.count_out), 0);
      bus.run = 1;
      tick(2);
      chk("rst_restart", 32'(bus.count_out), 1);
      bus.run = 0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
